fft_reorder: RTL
================

FFT_REORDER -- requirements
Module: fft_reorder

Interface
REQ-001 Parameter: N, 32, FFT length (points per frame); only 32 is supported.
REQ-002 Parameter: DW, 16, signed sample width per component.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 valid_i  input  1  data_in_r/data_in_i hold one FFT output sample, in bit-reversed order, this cycle.
REQ-006 data_in_r  input  DW  signed real part from the final FFT stage.
REQ-007 data_in_i  input  DW  signed imaginary part from the final FFT stage.
REQ-008 valid_o  output  1  data_out_r/data_out_i hold a natural-order bin this cycle.
REQ-009 data_out_r  output  DW  signed real part of bin X[index_o].
REQ-010 data_out_i  output  DW  signed imaginary part of bin X[index_o].
REQ-011 index_o  output  5  bin index of the current output, 0..31.
REQ-012 sof_o  output  1  one-cycle pulse coincident with X[0] of each frame.

Function
REQ-013 valid_i, data_in_r and data_in_i shall be registered once before any other use.
REQ-014 Write counter wc (5 bits) shall advance only on a registered valid sample; the sample is stored at address bitrev5(wc) of the current write bank.
REQ-015 Input gaps (valid_i low) of any length shall be tolerated; wc and the bank hold during a gap.
REQ-016 On wc wrap 31->0: the write bank toggles (ping-pong, 2 banks x 32 words x 2*DW) and the completed bank is handed to the read side.
REQ-017 Read FSM states: IDLE, READ; IDLE->READ on bank handoff; READ->IDLE after rc=31 unless another handoff is pending; READ->READ on a pending handoff, with no idle cycle between frames.
REQ-018 In READ, read counter rc shall step 0..31, one per cycle, addressing the read bank in natural order.
REQ-019 Latency: if edge E samples the 32nd input of a frame, X[0] shall appear on registered outputs after edge E+3, and X[k] after edge E+3+k.
REQ-020 valid_o shall be high for exactly 32 consecutive cycles per frame; index_o = rc of the displayed word; sof_o high only when index_o = 0 and valid_o = 1.
REQ-021 Data shall pass bit-exact: no scaling, rounding or saturation.
REQ-022 When valid_o = 0, data_out_r, data_out_i and index_o shall hold 0.
REQ-023 Back-to-back full-rate frames shall never overrun: the read of frame F shall finish before frame F+1's handoff is applied.
REQ-024 A partial frame (wc != 0) shall never be emitted; it completes only when its 32nd sample arrives.

Reset
REQ-025 Asserting rst_n low shall immediately clear valid_o, sof_o, data_out_r, data_out_i, index_o, wc, rc, the bank select, the pending flag and the FSM (IDLE), including mid-frame or mid-read.
REQ-026 Memory contents shall not be reset; no stale word shall be emitted after reset, because a bank is read only after 32 fresh writes.
REQ-027 The first valid_i after reset release shall be treated as sample 0 of a new frame.

Structure
REQ-028 The shared FFT package/include shall hold N, LOG2N = 5, DW, and the bitrev5 function.
REQ-029 The ping-pong storage shall be one sub-module, reorder_ram: 1 write port and 1 registered read port, 64 x 2*DW.
REQ-030 The top shall contain the input register, wc, bank select, read FSM and output register.

Verification
REQ-031 32 consecutive valid inputs with value n+j*(-n) at input position n -> 32 consecutive valid_o cycles; index k carries data (bitrev5(k), -bitrev5(k)); X[0] after edge E+3; sof_o pulses once.
REQ-032 Three frames back-to-back at full rate -> 96 consecutive valid_o cycles; each frame's 32 outputs are correct and contiguous; sof_o pulses 3 times, 32 cycles apart.
REQ-033 Frame sent with valid_i low on every other cycle -> output is identical to REQ-031 and stays a contiguous 32-cycle burst after the 32nd input.
REQ-034 rst_n pulsed low after 20 inputs, then a full frame -> no output from the aborted 20 samples; the new frame is correct.
REQ-035 Inputs of 0x7FFF and 0x8000 on both components -> outputs are bit-identical at the permuted index, with no sign or width corruption.
REQ-036 31 inputs followed by 100 idle cycles -> valid_o stays 0; the 32nd input then triggers a correct frame.

Source files
------------

// File: rtl/fft_reorder_pkg.sv
// fft_reorder_pkg: shared constants and helpers for the FFT output reorder path.
//   N      - FFT length (points per frame), only 32 supported
//   LOG2N  - address width of one frame
//   DW     - signed sample width per component
//   bitrev5 - reverse the 5 bits of an index (bit-reversed <-> natural order)
package fft_reorder_pkg;
  localparam int N     = 32;
  localparam int LOG2N = 5;
  localparam int DW    = 16;

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } rd_state_e;

  function automatic logic [LOG2N-1:0] bitrev5(input logic [LOG2N-1:0] a);
    logic [LOG2N-1:0] r;
    for (int b = 0; b < LOG2N; b++) r[b] = a[LOG2N-1-b];
    return r;
  endfunction
endpackage

// File: rtl/fft_reorder_ram.sv
// reorder_ram: ping-pong frame storage, 2 banks x 32 words x 2*DW.
//   clk   - clock
//   we    - write enable
//   waddr - {bank, word} write address
//   wdata - {real, imag} write data
//   raddr - {bank, word} read address
//   rdata - registered read data, valid one cycle after raddr
// Contents are intentionally not reset; the read side only ever reads a bank
// after all 32 words of it have been freshly written.
module reorder_ram #(
  parameter int DW = 16,
  parameter int AW = 6
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [2*DW-1:0] wdata,
  input  logic [AW-1:0]   raddr,
  output logic [2*DW-1:0] rdata
);
  logic [2*DW-1:0] mem [2**AW];
  logic [2*DW-1:0] rdata_d, rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_comb rdata_d = mem[raddr];

  always_ff @(posedge clk) rdata_q <= rdata_d;

  assign rdata = rdata_q;
endmodule

// File: rtl/fft_reorder.sv
// fft_reorder: converts bit-reversed FFT output into natural-order bins.
//   clk, rst_n             - clock, async active-low reset
//   valid_i                - input sample strobe
//   data_in_r, data_in_i   - signed sample in bit-reversed order
//   valid_o                - output bin strobe (32-cycle bursts per frame)
//   data_out_r, data_out_i - bin X[index_o], zero when valid_o is low
//   index_o                - natural bin index 0..31
//   sof_o                  - pulse with X[0] of each frame
// Flow: input reg -> write at bitrev5(wc) in write bank -> on wrap hand the
// bank to the read FSM -> natural-order read -> RAM read reg -> output reg.
module fft_reorder #(
  parameter int N  = 32,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          valid_i,
  input  logic [DW-1:0] data_in_r,
  input  logic [DW-1:0] data_in_i,
  output logic          valid_o,
  output logic [DW-1:0] data_out_r,
  output logic [DW-1:0] data_out_i,
  output logic [4:0]    index_o,
  output logic          sof_o
);
  import fft_reorder_pkg::*;

  logic            in_vld_q;
  logic [DW-1:0]   in_r_q, in_i_q;
  logic [4:0]      wc_d, wc_q;
  logic            wr_bank_d, wr_bank_q;
  logic            handoff;
  rd_state_e       state_d, state_q;
  logic [4:0]      rc_d, rc_q;
  logic            rd_bank_d, rd_bank_q;
  logic            pend_d, pend_q, pend_bank_d, pend_bank_q;
  logic [2:1]      vld_pipe_d, vld_pipe_q;
  logic [4:0]      rc_p1_d, rc_p1_q;
  logic [4:0]      idx_d, idx_q;
  logic [DW-1:0]   out_r_d, out_r_q, out_i_d, out_i_q;
  logic            sof_d, sof_q;
  logic [2*DW-1:0] rdata;

  // the word at wc == 31 completes the frame in the current write bank
  assign handoff = in_vld_q && (wc_q == 5'd31);

  always_comb begin
    wc_d      = wc_q;
    wr_bank_d = wr_bank_q;
    if (in_vld_q) begin
      wc_d = wc_q + 5'd1;
      if (wc_q == 5'd31) wr_bank_d = ~wr_bank_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    rc_d        = rc_q;
    rd_bank_d   = rd_bank_q;
    pend_d      = pend_q;
    pend_bank_d = pend_bank_q;
    case (state_q)
      IDLE: begin
        if (handoff) begin
          state_d   = READ;
          rc_d      = 5'd0;
          rd_bank_d = wr_bank_q;
        end
      end
      READ: begin
        rc_d = rc_q + 5'd1;  // wraps to 0 after 31
        if (rc_q == 5'd31) begin
          if (handoff) begin
            rd_bank_d = wr_bank_q;
          end else if (pend_q) begin
            rd_bank_d = pend_bank_q;
            pend_d    = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else if (handoff) begin
          // frames are >= 32 cycles apart so this cannot occur at full rate,
          // but a completed bank is never dropped
          pend_d      = 1'b1;
          pend_bank_d = wr_bank_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    vld_pipe_d = {vld_pipe_q[1], state_q == READ};
    rc_p1_d    = rc_q;
    out_r_d    = vld_pipe_q[1] ? rdata[2*DW-1:DW] : '0;
    out_i_d    = vld_pipe_q[1] ? rdata[DW-1:0]    : '0;
    idx_d      = vld_pipe_q[1] ? rc_p1_q          : 5'd0;
    sof_d      = vld_pipe_q[1] && (rc_p1_q == 5'd0);
  end

  reorder_ram #(.DW(DW), .AW(LOG2N + 1)) u_ram (
    .clk   (clk),
    .we    (in_vld_q),
    .waddr ({wr_bank_q, bitrev5(wc_q)}),
    .wdata ({in_r_q, in_i_q}),
    .raddr ({rd_bank_q, rc_q}),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_vld_q    <= 1'b0;
      in_r_q      <= '0;
      in_i_q      <= '0;
      wc_q        <= 5'd0;
      wr_bank_q   <= 1'b0;
      state_q     <= IDLE;
      rc_q        <= 5'd0;
      rd_bank_q   <= 1'b0;
      pend_q      <= 1'b0;
      pend_bank_q <= 1'b0;
      vld_pipe_q  <= '0;
      rc_p1_q     <= 5'd0;
      idx_q       <= 5'd0;
      out_r_q     <= '0;
      out_i_q     <= '0;
      sof_q       <= 1'b0;
    end else begin
      in_vld_q    <= valid_i;
      in_r_q      <= data_in_r;
      in_i_q      <= data_in_i;
      wc_q        <= wc_d;
      wr_bank_q   <= wr_bank_d;
      state_q     <= state_d;
      rc_q        <= rc_d;
      rd_bank_q   <= rd_bank_d;
      pend_q      <= pend_d;
      pend_bank_q <= pend_bank_d;
      vld_pipe_q  <= vld_pipe_d;
      rc_p1_q     <= rc_p1_d;
      idx_q       <= idx_d;
      out_r_q     <= out_r_d;
      out_i_q     <= out_i_d;
      sof_q       <= sof_d;
    end
  end

  assign valid_o    = vld_pipe_q[2];
  assign data_out_r = out_r_q;
  assign data_out_i = out_i_q;
  assign index_o    = idx_q;
  assign sof_o      = sof_q;
endmodule
